// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by pwm_duty_ramp and pwm_generator.
// Holds the default duty/counter width and the ramp controller state type.
package pwm_pkg;

  // Default duty and period-counter width used by the PWM blocks.
  localparam int PWM_WIDTH = 8;

  // Ramp controller states: waiting for a target, or slewing toward one.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: WIDTH-bit free-running counter that mirrors the
// pwm_generator counter (same clock, same reset, 0 .. 2^WIDTH-1, wraps).
// o_boundary is high for exactly the cycle in which the count is all-ones.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic clk_fpga,
  input  logic reset_n,
  output logic o_boundary
);

  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             bnd_q;
  logic             bnd_d;

  // Next count, and whether that next count is the last one of the period.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1'b1);
    if (cnt_d == CNT_LAST) begin
      bnd_d = 1'b1;
    end else begin
      bnd_d = 1'b0;
    end
  end

  // Counter and registered boundary flag; the flag tracks cnt_q == all-ones.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WIDTH{1'b0}};
      bnd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bnd_q <= bnd_d;
    end
  end

  assign o_boundary = bnd_q;

endmodule : pwm_period_counter

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: accepts a target duty over valid/ready and moves the applied
// duty toward it, changing o_duty_cycle only on the edge that ends a PWM
// period, so the generator never sees a mid-period change.
// Build option PWM_DUTY_RAMP_SLEW_EN: when defined, the duty moves by STEP
// every PERIODS_PER_STEP periods; when undefined, an accepted target is
// applied whole at the next period boundary.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int WIDTH            = PWM_WIDTH,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic             clk_fpga,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_target_valid,
  output logic             o_target_ready,
  output logic [WIDTH-1:0] o_duty_cycle,
  output logic             o_period_start,
  output logic             o_busy
);

  // Reject parameter sets that would make the step arithmetic meaningless.
  if ((STEP < 1) || (STEP > (2 ** WIDTH) - 1) || (PERIODS_PER_STEP < 1)) begin : g_cfg_check
    $error("pwm_duty_ramp: STEP or PERIODS_PER_STEP out of range");
  end

  pwm_state_e       state_q;
  pwm_state_e       state_d;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_d;
  logic             ready_q;
  logic             ready_d;
  logic             busy_q;
  logic             busy_d;

  logic             boundary_s;
  logic             accept_s;
  logic             update_due_s;
  logic [WIDTH-1:0] update_val_s;

  // Period counter running in lockstep with the generator's counter.
  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_period_counter (
    .clk_fpga   (clk_fpga),
    .reset_n    (reset_n),
    .o_boundary (boundary_s)
  );

  // A target is taken only while ready is high (IDLE).
  assign accept_s = i_target_valid & ready_q;

`ifdef PWM_DUTY_RAMP_SLEW_EN

  // The step-period counter must be able to hold PERIODS_PER_STEP itself.
  localparam int                 SPC_W    = $clog2(PERIODS_PER_STEP + 1);
  localparam logic [SPC_W-1:0]   SPC_LAST = SPC_W'(PERIODS_PER_STEP);
  localparam logic [WIDTH:0]     STEP_X   = (WIDTH + 1)'(STEP);

  logic [SPC_W-1:0] spc_q;
  logic [SPC_W-1:0] spc_d;
  logic [SPC_W-1:0] spc_inc_s;

  // One step from duty toward tgt, computed one bit wider so that neither
  // the sum nor the difference can wrap; the result is clamped at tgt.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] duty,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0]   duty_x;
    logic [WIDTH:0]   tgt_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic [WIDTH-1:0] res;
    duty_x = {1'b0, duty};
    tgt_x  = {1'b0, tgt};
    sum_x  = duty_x + STEP_X;
    diff_x = duty_x - STEP_X;
    if (tgt_x > duty_x) begin
      if (sum_x >= tgt_x) begin
        res = tgt;
      end else begin
        res = sum_x[WIDTH-1:0];
      end
    end else begin
      // A set top bit means duty < STEP: the difference went negative.
      if (diff_x[WIDTH] || (diff_x <= tgt_x)) begin
        res = tgt;
      end else begin
        res = diff_x[WIDTH-1:0];
      end
    end
    return res;
  endfunction

  // A step is due on the boundary that brings the period count to the limit.
  always_comb begin
    spc_inc_s    = spc_q + SPC_W'(1'b1);
    update_val_s = step_toward(duty_q, target_q);
    if ((state_q == ST_RAMP) && boundary_s && (spc_inc_s == SPC_LAST)) begin
      update_due_s = 1'b1;
    end else begin
      update_due_s = 1'b0;
    end
  end

  // Step-period counter: cleared on acceptance, counts RAMP boundaries only.
  always_comb begin
    spc_d = spc_q;
    if (state_q == ST_IDLE) begin
      if (accept_s) begin
        spc_d = {SPC_W{1'b0}};
      end else begin
        spc_d = spc_q;
      end
    end else if (boundary_s) begin
      if (spc_inc_s == SPC_LAST) begin
        spc_d = {SPC_W{1'b0}};
      end else begin
        spc_d = spc_inc_s;
      end
    end else begin
      spc_d = spc_q;
    end
  end

  // Step-period counter register.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      spc_q <= {SPC_W{1'b0}};
    end else begin
      spc_q <= spc_d;
    end
  end

`else

  // Without slewing the whole target lands on the first RAMP boundary; a
  // boundary in the accepting cycle is seen in IDLE and so does not count.
  always_comb begin
    update_val_s = target_q;
    if ((state_q == ST_RAMP) && boundary_s) begin
      update_due_s = 1'b1;
    end else begin
      update_due_s = 1'b0;
    end
  end

`endif

  // Controller: accept a differing target, apply updates at boundaries, and
  // drop back to IDLE on the same edge that makes the duty reach the target.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (i_target != duty_q)) begin
          target_d = i_target;
          state_d  = ST_RAMP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (update_due_s) begin
          duty_d = update_val_s;
          if (update_val_s == target_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          state_d = ST_RAMP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_RAMP);
  end

  // State, applied duty, latched target and handshake flags.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      duty_q   <= {WIDTH{1'b0}};
      target_q <= {WIDTH{1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign o_duty_cycle   = duty_q;
  assign o_target_ready = ready_q;
  assign o_busy         = busy_q;
  assign o_period_start = boundary_s;

endmodule : pwm_duty_ramp
